spi_flash_arbiter: RTL

Shares the single SPI flash engine (spi_enable / spi_idle / tx / rx byte-stream user interface) between two requesters: port A (boot-time flash-to-SPRAM loader) and port B (runtime flash client, e.g. save-data or asset reads). It grants whole transactions, enforces a chip-select guard gap between owners, and routes the engine's strobes and data only to the current owner.

---
 rtl/spi_flash_arbiter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/spi_flash_arbiter.sv
// Two-port arbiter in front of one SPI flash engine: grants whole transactions,
// inserts a chip-select guard gap between owners and routes strobes/data to the owner only.
module spi_flash_arbiter #(
   parameter int ARB_MODE     = 0,
   parameter int GUARD_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        a_req,
   input  logic        b_req,
   output logic        a_gnt,
   output logic        b_gnt,
   input  logic        a_enable,
   input  logic        b_enable,
   input  logic [7:0]  a_tx_len,
   input  logic [7:0]  b_tx_len,
   input  logic [7:0]  a_tx_data,
   input  logic [7:0]  b_tx_data,
   input  logic [23:0] a_rx_len,
   input  logic [23:0] b_rx_len,
   output logic        a_idle,
   output logic        b_idle,
   output logic        a_tx_fetch,
   output logic        b_tx_fetch,
   output logic        a_rx_store,
   output logic        b_rx_store,
   output logic [7:0]  a_rx_data,
   output logic [7:0]  b_rx_data,
   output logic        spi_enable,
   input  logic        spi_idle,
   output logic [7:0]  spi_tx_len,
   input  logic        spi_tx_fetch,
   output logic [7:0]  spi_tx_data,
   output logic [23:0] spi_rx_len,
   input  logic        spi_rx_store,
   input  logic [7:0]  spi_rx_data,
   output logic        owner,
   output logic        busy
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_BUSY  = 2'd2;
   localparam logic [1:0] S_GUARD = 2'd3;

   localparam logic [7:0] GUARD_LAST = 8'(GUARD_CYCLES);

   logic [1:0] state;
   logic [7:0] guard_cnt;
   logic       idle_q;
   logic       last_b;
   logic       own_en;
   logic       own_req;
   logic       pick_b;
   logic       idle_rise;

   // In round-robin mode a tie goes to whoever was not granted last
   always_comb begin
      own_en    = owner ? b_enable : a_enable;
      own_req   = owner ? b_req : a_req;
      idle_rise = spi_idle & ~idle_q;
      if (ARB_MODE == 1)
         pick_b = ~a_req;
      else if (a_req & b_req)
         pick_b = ~last_b;
      else
         pick_b = ~a_req;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         a_gnt     <= 1'b0;
         b_gnt     <= 1'b0;
         owner     <= 1'b0;
         busy      <= 1'b0;
         guard_cnt <= 8'd0;
         idle_q    <= 1'b0;
         last_b    <= 1'b1;
      end else begin
         idle_q <= spi_idle;
         case (state)
            S_IDLE: begin
               if ((a_req | b_req) && spi_idle) begin
                  state  <= S_GRANT;
                  a_gnt  <= ~pick_b;
                  b_gnt  <= pick_b;
                  owner  <= pick_b;
                  last_b <= pick_b;
               end
            end
            // An enable in the same cycle as a req drop still issues the transaction
            S_GRANT: begin
               if (own_en) begin
                  state <= S_BUSY;
                  busy  <= 1'b1;
               end else if (!own_req) begin
                  state     <= S_GUARD;
                  a_gnt     <= 1'b0;
                  b_gnt     <= 1'b0;
                  guard_cnt <= 8'd1;
               end
            end
            S_BUSY: begin
               if (idle_rise) begin
                  state <= S_GRANT;
                  busy  <= 1'b0;
               end
            end
            S_GUARD: begin
               if (guard_cnt >= GUARD_LAST) begin
                  state     <= S_IDLE;
                  guard_cnt <= 8'd0;
               end else begin
                  guard_cnt <= guard_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Grants are one-hot or zero, so they select the owner's paths directly
   assign spi_enable  = (state == S_GRANT) & ((a_gnt & a_enable) | (b_gnt & b_enable));
   assign spi_tx_len  = a_gnt ? a_tx_len  : (b_gnt ? b_tx_len  : 8'd0);
   assign spi_tx_data = a_gnt ? a_tx_data : (b_gnt ? b_tx_data : 8'd0);
   assign spi_rx_len  = a_gnt ? a_rx_len  : (b_gnt ? b_rx_len  : 24'd0);
   assign a_tx_fetch  = spi_tx_fetch & a_gnt;
   assign b_tx_fetch  = spi_tx_fetch & b_gnt;
   assign a_rx_store  = spi_rx_store & a_gnt;
   assign b_rx_store  = spi_rx_store & b_gnt;
   assign a_rx_data   = a_gnt ? spi_rx_data : 8'd0;
   assign b_rx_data   = b_gnt ? spi_rx_data : 8'd0;
   assign a_idle      = spi_idle & a_gnt & (state == S_GRANT);
   assign b_idle      = spi_idle & b_gnt & (state == S_GRANT);

endmodule
